pipelined_cla_adder: RTL and testbench



---
 rtl/pipelined_cla_adder.sv | 143 ++++++++++++++
 tb/tb_pipelined_cla_adder.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-look-ahead adder/subtractor: one K-bit look-ahead block per stage, valid/ready handshake.
// Optional signed-overflow output `ovf` is built when PIPELINED_CLA_OVF_EN is defined.
module pipelined_cla_adder #(
    parameter int N = 8,
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         C_in,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] S,
    output logic         C_out
`ifdef PIPELINED_CLA_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int STAGES = N / K;
    localparam logic [N-1:0] BLK_MASK = N'({K{1'b1}});

    // Every carry of the block is a flat sum of generate/propagate products, so no ripple chain.
    function automatic logic [K:0] cla_carries(input logic [K-1:0] g,
                                               input logic [K-1:0] p,
                                               input logic         ci);
        logic [K:0] gc;
        logic [K:0] c;
        logic       t;
        gc   = {g, ci};
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < K; i++) begin
            c[i+1] = 1'b0;
            for (int j = 0; j <= i + 1; j++) begin
                t = gc[j];
                for (int m = j; m <= i; m++) begin
                    t = t & p[m];
                end
                c[i+1] = c[i+1] | t;
            end
        end
        return c;
    endfunction

    logic         w_adv;
    logic [N-1:0] w_beff;
    logic         w_cin;

    // r_as[j] packs the untouched upper operand-A bits above the sum bits resolved so far.
    logic         r_vld [STAGES];
    logic [N-1:0] r_as  [STAGES];
    logic [N-1:0] r_b   [STAGES];
    logic         r_c   [STAGES];

    logic [N-1:0] w_as_nx  [STAGES];
    logic [N-1:0] w_b_src  [STAGES];
    logic         w_c_nx   [STAGES];

`ifdef PIPELINED_CLA_OVF_EN
    logic w_cm_last;
    logic r_cm;
`endif

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;
    assign w_beff   = sub ? ~B : B;
    assign w_cin    = sub ? 1'b1 : C_in;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic [N-1:0] w_as_src;
        logic         w_c_src;
        logic [K-1:0] w_g;
        logic [K-1:0] w_p;
        logic [K-1:0] w_sum;
        logic [K:0]   w_cc;

        if (gi == 0) begin : g_head
            assign w_as_src    = A;
            assign w_b_src[gi] = w_beff;
            assign w_c_src     = w_cin;
        end else begin : g_body
            assign w_as_src    = r_as[gi-1];
            assign w_b_src[gi] = r_b[gi-1];
            assign w_c_src     = r_c[gi-1];
        end

        assign w_g   = w_as_src[gi*K +: K] & w_b_src[gi][gi*K +: K];
        assign w_p   = w_as_src[gi*K +: K] ^ w_b_src[gi][gi*K +: K];
        assign w_cc  = cla_carries(w_g, w_p, w_c_src);
        assign w_sum = w_p ^ w_cc[K-1:0];

        assign w_as_nx[gi] = (w_as_src & ~(BLK_MASK << (gi * K))) | (N'(w_sum) << (gi * K));
        assign w_c_nx[gi]  = w_cc[K];

`ifdef PIPELINED_CLA_OVF_EN
        if (gi == STAGES - 1) begin : g_msb
            assign w_cm_last = w_cc[K-1];
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < STAGES; j++) begin
                r_vld[j] <= 1'b0;
                r_as[j]  <= '0;
                r_b[j]   <= '0;
                r_c[j]   <= 1'b0;
            end
`ifdef PIPELINED_CLA_OVF_EN
            r_cm <= 1'b0;
`endif
        end else if (w_adv) begin
            r_vld[0] <= in_valid;
            for (int j = 1; j < STAGES; j++) begin
                r_vld[j] <= r_vld[j-1];
            end
            for (int j = 0; j < STAGES; j++) begin
                r_as[j] <= w_as_nx[j];
                r_b[j]  <= w_b_src[j];
                r_c[j]  <= w_c_nx[j];
            end
`ifdef PIPELINED_CLA_OVF_EN
            r_cm <= w_cm_last;
`endif
        end
    end

    assign out_valid = r_vld[STAGES-1];
    assign S         = r_as[STAGES-1];
    assign C_out     = r_c[STAGES-1];

`ifdef PIPELINED_CLA_OVF_EN
    assign ovf = r_cm ^ r_c[STAGES-1];
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench: directed vectors and randomized streams against an arithmetic reference model.
module tb_pipelined_cla_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0;

    logic       iv8, ir8, ov8, or8, cin8, sub8, co8;
    logic [7:0] a8, b8, s8;
    logic        iv16, ir16, ov16, or16, cin16, sub16, co16;
    logic [15:0] a16, b16, s16;
    logic       iv4, ir4, ov4, or4, cin4, sub4, co4;
    logic [3:0] a4, b4, s4;
`ifdef PIPELINED_CLA_OVF_EN
    logic ovf8, ovf16, ovf4;
`endif

    int total = 0;
    int bad   = 0;

    pipelined_cla_adder #(.N(8), .K(4)) u8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
        .C_in(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .S(s8), .C_out(co8)
`ifdef PIPELINED_CLA_OVF_EN
        , .ovf(ovf8)
`endif
    );

    pipelined_cla_adder #(.N(16), .K(4)) u16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .A(a16), .B(b16),
        .C_in(cin16), .sub(sub16), .out_valid(ov16), .out_ready(or16), .S(s16), .C_out(co16)
`ifdef PIPELINED_CLA_OVF_EN
        , .ovf(ovf16)
`endif
    );

    pipelined_cla_adder #(.N(4), .K(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .A(a4), .B(b4),
        .C_in(cin4), .sub(sub4), .out_valid(ov4), .out_ready(or4), .S(s4), .C_out(co4)
`ifdef PIPELINED_CLA_OVF_EN
        , .ovf(ovf4)
`endif
    );

    // {C_out,S} as an (n+1)-bit number: A+B+C_in, or A-B offset by 2^n (no borrow sets C_out).
    function automatic longint ref_sum(input int n, input longint a, input longint b,
                                       input bit cin, input bit sb);
        longint m;
        longint r;
        m = longint'(1) << n;
        if (sb) r = a + m - b;
        else    r = a + b + longint'(cin);
        return r % (2 * m);
    endfunction

    localparam logic [7:0] VEC_A [4] = '{8'h0F, 8'hFF, 8'hAA, 8'h05};
    localparam logic [7:0] VEC_B [4] = '{8'h01, 8'hFF, 8'h55, 8'h07};
    localparam logic       VEC_C [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    localparam logic       VEC_S [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic [8:0] VEC_X [4] = '{9'h010, 9'h1FE, 9'h100, 9'h0FE};

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++; if (ov8 !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", ov8); end
        total++; if (s8 !== 8'h00) begin bad++; $display("FAIL reset_S got=%h want=00", s8); end
        total++; if (co8 !== 1'b0) begin bad++; $display("FAIL reset_C_out got=%b want=0", co8); end
        total++; if (ov16 !== 1'b0) begin bad++; $display("FAIL reset_out_valid16 got=%b want=0", ov16); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (ir8 !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", ir8); end
        $display("reset: checked outputs during and after reset");
    endtask

    task automatic test_arith_table();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            iv8 = 1'b1; a8 = VEC_A[i]; b8 = VEC_B[i]; cin8 = VEC_C[i]; sub8 = VEC_S[i]; or8 = 1'b1;
            #1;
            total++; if (ir8 !== 1'b1) begin bad++; $display("FAIL table_in_ready[%0d] got=%b want=1", i, ir8); end
            @(negedge clk);
            iv8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; sub8 = 1'b0;
            #1;
            total++; if (ov8 !== 1'b0) begin bad++; $display("FAIL table_early[%0d] got=%b want=0", i, ov8); end
            @(negedge clk);
            #1;
            total++; if (ov8 !== 1'b1) begin bad++; $display("FAIL table_latency[%0d] got=%b want=1", i, ov8); end
            total++; if ({co8, s8} !== VEC_X[i]) begin bad++; $display("FAIL table_sum[%0d] got=%h want=%h", i, {co8, s8}, VEC_X[i]); end
            @(negedge clk);
            #1;
            total++; if (ov8 !== 1'b0) begin bad++; $display("FAIL table_bubble[%0d] got=%b want=0", i, ov8); end
            $display("vector %0d: A=%h B=%h cin=%b sub=%b -> {C_out,S}=%h", i, VEC_A[i], VEC_B[i], VEC_C[i], VEC_S[i], VEC_X[i]);
        end
    endtask

`ifdef PIPELINED_CLA_OVF_EN
    task automatic test_overflow();
        logic [7:0] oa [4];
        logic [7:0] ob [4];
        logic       os [4];
        logic [7:0] oexp [4];
        logic       ovexp [4];
        oa = '{8'h80, 8'h7F, 8'h10, 8'hFF};
        ob = '{8'h01, 8'h01, 8'h20, 8'h01};
        os = '{1'b1, 1'b0, 1'b0, 1'b0};
        oexp = '{8'h7F, 8'h80, 8'h30, 8'h00};
        ovexp = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            iv8 = 1'b1; a8 = oa[i]; b8 = ob[i]; cin8 = 1'b0; sub8 = os[i]; or8 = 1'b1;
            @(negedge clk);
            iv8 = 1'b0;
            @(negedge clk);
            #1;
            total++; if (s8 !== oexp[i]) begin bad++; $display("FAIL ovf_sum[%0d] got=%h want=%h", i, s8, oexp[i]); end
            total++; if (ovf8 !== ovexp[i]) begin bad++; $display("FAIL ovf_flag[%0d] got=%b want=%b", i, ovf8, ovexp[i]); end
            $display("ovf vector %0d: S=%h ovf=%b", i, s8, ovf8);
        end
    endtask
`endif

    task automatic test_backpressure();
        logic [8:0] q[$];
        int sent = 0;
        int got  = 0;
        bit need = 1'b1;
        bit stall;
        for (int k = 0; k < 30 && got < 4; k++) begin
            @(negedge clk);
            stall = (k >= 3 && k <= 5);
            or8 = !stall;
            if (sent < 4) begin
                if (need) begin
                    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
                    need = 1'b0;
                end
                iv8 = 1'b1;
            end else begin
                iv8 = 1'b0;
            end
            #1;
            total++; if (ir8 !== !stall) begin bad++; $display("FAIL bp_in_ready[c%0d] got=%b want=%b", k, ir8, !stall); end
            if (stall) begin
                total++; if (ov8 !== 1'b1) begin bad++; $display("FAIL bp_stall_valid[c%0d] got=%b want=1", k, ov8); end
            end
            if (ov8 === 1'b1) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL bp_spurious[c%0d] got=%h want=none", k, {co8, s8});
                end else begin
                    if ({co8, s8} !== q[0]) begin bad++; $display("FAIL bp_sum[c%0d] got=%h want=%h", k, {co8, s8}, q[0]); end
                    if (or8) begin
                        $display("bp out c%0d: {C_out,S}=%h", k, {co8, s8});
                        void'(q.pop_front());
                        got++;
                    end
                end
            end
            if (iv8 && ir8) begin
                q.push_back(9'(ref_sum(8, a8, b8, cin8, sub8)));
                sent++;
                need = 1'b1;
            end
        end
        total++; if (got !== 4) begin bad++; $display("FAIL bp_count got=%0d want=4", got); end
        iv8 = 1'b0; or8 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            total++; if (ov8 !== 1'b0) begin bad++; $display("FAIL bp_duplicate[%0d] got=%b want=0", k, ov8); end
        end
    endtask

    task automatic test_reset_midflight();
        or8 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            iv8 = 1'b1; a8 = 8'($urandom) | 8'h01; b8 = 8'($urandom); cin8 = 1'b0; sub8 = 1'b0;
        end
        @(negedge clk);
        iv8 = 1'b0;
        #1;
        total++; if (ov8 !== 1'b1) begin bad++; $display("FAIL mid_before got=%b want=1", ov8); end
        #1;
        rst = 1'b1;
        #1;
        total++; if (ov8 !== 1'b0) begin bad++; $display("FAIL mid_out_valid got=%b want=0", ov8); end
        total++; if ({co8, s8} !== 9'h000) begin bad++; $display("FAIL mid_S got=%h want=000", {co8, s8}); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (ir8 !== 1'b1) begin bad++; $display("FAIL mid_in_ready got=%b want=1", ir8); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            total++; if (ov8 !== 1'b0) begin bad++; $display("FAIL mid_stale[%0d] got=%b want=0", k, ov8); end
        end
        $display("reset mid-flight: in-flight beats discarded");
    endtask

    task automatic test_latency16();
        logic [16:0] exp_v;
        @(negedge clk);
        iv16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 1'b0; sub16 = 1'b0; or16 = 1'b1;
        exp_v = 17'(ref_sum(16, a16, b16, cin16, sub16));
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            iv16 = 1'b0;
            #1;
            total++; if (ov16 !== (k == 4)) begin bad++; $display("FAIL lat16[c%0d] got=%b want=%b", k, ov16, (k == 4)); end
            if (k == 4) begin
                total++; if ({co16, s16} !== exp_v) begin bad++; $display("FAIL lat16_sum got=%h want=%h", {co16, s16}, exp_v); end
                $display("lat16: out_valid at cycle %0d, {C_out,S}=%h", k, {co16, s16});
            end
        end
    endtask

    task automatic test_random16();
        logic [16:0] q[$];
        int sent = 0;
        int got  = 0;
        bit need = 1'b1;
        for (int k = 0; k < 20000 && got < 1000; k++) begin
            @(negedge clk);
            or16 = ($urandom_range(0, 3) != 0);
            if (sent < 1000 && $urandom_range(0, 9) < 7) begin
                if (need) begin
                    a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom); sub16 = 1'($urandom);
                    need = 1'b0;
                end
                iv16 = 1'b1;
            end else begin
                iv16 = 1'b0;
            end
            #1;
            if (ov16 === 1'b1) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL rnd16_spurious[c%0d] got=%h want=none", k, {co16, s16});
                end else begin
                    if ({co16, s16} !== q[0]) begin bad++; $display("FAIL rnd16_sum[beat %0d] got=%h want=%h", got, {co16, s16}, q[0]); end
                    if (or16) begin
                        $display("rnd16 beat %0d: {C_out,S}=%h", got, {co16, s16});
                        void'(q.pop_front());
                        got++;
                    end
                end
            end
            if (iv16 && ir16) begin
                q.push_back(17'(ref_sum(16, a16, b16, cin16, sub16)));
                sent++;
                need = 1'b1;
            end
        end
        iv16 = 1'b0; or16 = 1'b1;
        total++; if (got !== 1000) begin bad++; $display("FAIL rnd16_count got=%0d want=1000", got); end
    endtask

    task automatic test_single_stage();
        logic [4:0] q[$];
        int sent = 0;
        int got  = 0;
        bit need = 1'b1;
        @(negedge clk);
        iv4 = 1'b1; a4 = 4'hF; b4 = 4'h1; cin4 = 1'b0; sub4 = 1'b0; or4 = 1'b1;
        @(negedge clk);
        iv4 = 1'b0;
        #1;
        total++; if (ov4 !== 1'b1) begin bad++; $display("FAIL s1_latency got=%b want=1", ov4); end
        total++; if ({co4, s4} !== 5'h10) begin bad++; $display("FAIL s1_wrap got=%h want=10", {co4, s4}); end
        $display("single stage: F+1 -> {C_out,S}=%h", {co4, s4});
        for (int k = 0; k < 2000 && got < 200; k++) begin
            @(negedge clk);
            or4 = ($urandom_range(0, 2) != 0);
            if (sent < 200 && $urandom_range(0, 3) != 0) begin
                if (need) begin
                    a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom); sub4 = 1'($urandom);
                    need = 1'b0;
                end
                iv4 = 1'b1;
            end else begin
                iv4 = 1'b0;
            end
            #1;
            if (ov4 === 1'b1) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL s1_spurious[c%0d] got=%h want=none", k, {co4, s4});
                end else begin
                    if ({co4, s4} !== q[0]) begin bad++; $display("FAIL s1_sum[beat %0d] got=%h want=%h", got, {co4, s4}, q[0]); end
                    if (or4) begin
                        void'(q.pop_front());
                        got++;
                    end
                end
            end
            if (iv4 && ir4) begin
                q.push_back(5'(ref_sum(4, a4, b4, cin4, sub4)));
                sent++;
                need = 1'b1;
            end
        end
        iv4 = 1'b0; or4 = 1'b1;
        total++; if (got !== 200) begin bad++; $display("FAIL s1_count got=%0d want=200", got); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        iv8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
        iv16 = 1'b0; or16 = 1'b1; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0;
        iv4 = 1'b0; or4 = 1'b1; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0;
        test_reset();
        test_arith_table();
`ifdef PIPELINED_CLA_OVF_EN
        test_overflow();
`endif
        test_backpressure();
        test_reset_midflight();
        test_latency16();
        test_random16();
        test_single_stage();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
